// File: rtl/key_debouncer_n.sv
// key_debouncer_n: per-channel synchronise + debounce of button pins, with press/release, long-press and auto-repeat pulses.
module key_debouncer_n #(
    parameter int CHANNELS      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] buttons_in,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic IDLE = ACTIVE_LOW != 0;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    genvar c;
    for (c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SW-1:0]          stab_q, stab_d;
        logic [HW-1:0]          hold_q, hold_d;
        logic                   pressed_q, pressed_d, press_q, press_d;
        logic                   rel_q, rel_d, long_q, long_d;
        logic                   raw, commit, held_long;

        assign raw       = sync_q[SYNC_STAGES-1] ^ IDLE;
        assign commit    = (raw != pressed_q) && (stab_q == STAB_MAX);
        assign held_long = pressed_q && !commit && (hold_q == HOLD_MAX);

        always_comb begin
            stab_d    = (raw == pressed_q || commit) ? '0 : stab_q + 1'b1;
            pressed_d = commit ? raw : pressed_q;
            press_d   = commit && raw;
            rel_d     = commit && !raw;
            hold_d    = (!pressed_q || commit) ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            long_d    = pressed_q && !commit && (hold_q == HOLD_PRE);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q    <= {SYNC_STAGES{IDLE}};
                stab_q    <= '0;
                hold_q    <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], buttons_in[c]};
                stab_q    <= stab_d;
                hold_q    <= hold_d;
                pressed_q <= pressed_d;
                press_q   <= press_d;
                rel_q     <= rel_d;
                long_q    <= long_d;
            end
        end

        assign pressed[c]          = pressed_q;
        assign press_pulse[c]      = press_q;
        assign release_pulse[c]    = rel_q;
        assign long_press_pulse[c] = long_q;

        if (REPEAT_CYCLES > 0) begin : g_rep
            localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
            logic [RW-1:0] rep_q, rep_d;
            logic          rep_pulse_q, rep_pulse_d;
            // Phase is anchored at the long-press edge (counter held at 0 until then), so the period never drifts.
            always_comb begin
                rep_d       = !held_long ? '0 : (rep_q == REP_MAX) ? '0 : rep_q + 1'b1;
                rep_pulse_d = held_long && (rep_q == REP_MAX);
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    rep_q       <= '0;
                    rep_pulse_q <= 1'b0;
                end else begin
                    rep_q       <= rep_d;
                    rep_pulse_q <= rep_pulse_d;
                end
            end
            assign repeat_pulse[c] = rep_pulse_q;
        end else begin : g_norep
            assign repeat_pulse[c] = 1'b0;
        end
    end
endmodule

// File: tb/tb_key_debouncer_n.sv
// tb_key_debouncer_n: directed plus random stimulus against an event-timestamp reference model.
module tb_key_debouncer_n;
    localparam int CH = 4, AL = 1, SYNC = 2, STABLE = 4, HOLD = 20, REP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] buttons_in;
    logic [CH-1:0] pressed, press_pulse, release_pulse, long_press_pulse, repeat_pulse;

    key_debouncer_n #(
        .CHANNELS(CH), .ACTIVE_LOW(AL), .SYNC_STAGES(SYNC),
        .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .buttons_in(buttons_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press_pulse(long_press_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_edge = 0;
    bit mp[CH];
    int run_start[CH];
    int press_at[CH];
    bit hist[CH][$];
    logic [CH-1:0] e_pr, e_pp, e_rp, e_lp, e_rep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, obs, exp);
        end
    endtask

    // Model: pin history delayed by the synchroniser, commit after STABLE consecutive mismatching edges,
    // long press and repeats derived from the press-commit timestamp.
    task automatic model();
        n_edge++;
        e_pp = '0; e_rp = '0; e_lp = '0; e_rep = '0;
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                mp[c] = 0; run_start[c] = -1; press_at[c] = -1;
                hist[c].delete();
                for (int k = 0; k < SYNC; k++) hist[c].push_back(1'b0);
            end else begin
                automatic bit v, old;
                automatic int h;
                hist[c].push_back(buttons_in[c] ^ AL[0]);
                v = hist[c].pop_front();
                old = mp[c];
                if (v == mp[c]) run_start[c] = -1;
                else begin
                    if (run_start[c] < 0) run_start[c] = n_edge;
                    if (n_edge - run_start[c] + 1 == STABLE) begin
                        mp[c] = v;
                        run_start[c] = -1;
                        if (v) begin e_pp[c] = 1'b1; press_at[c] = n_edge; end
                        else e_rp[c] = 1'b1;
                    end
                end
                h = n_edge - press_at[c];
                if (old && !e_rp[c]) begin
                    e_lp[c]  = (h == HOLD);
                    e_rep[c] = (REP > 0) && (h > HOLD) && ((h - HOLD) % REP == 0);
                end
            end
            e_pr[c] = mp[c];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        check("pressed", 32'(pressed), 32'(e_pr));
        check("press_pulse", 32'(press_pulse), 32'(e_pp));
        check("release_pulse", 32'(release_pulse), 32'(e_rp));
        check("long_press", 32'(long_press_pulse), 32'(e_lp));
        check("repeat", 32'(repeat_pulse), 32'(e_rep));
    endtask

    int edges;
    int rem[CH];

    initial begin
        reset = 1'b1;
        buttons_in = '1;
        repeat (3) step();
        reset = 1'b0;
        repeat (60) step();

        buttons_in[0] = 1'b0;
        edges = 0;
        do begin step(); edges++; end while (!press_pulse[0] && edges < 20);
        check("press_latency", 32'(edges), 32'd6);
        repeat (3) step();
        buttons_in[0] = 1'b1;
        edges = 0;
        do begin step(); edges++; end while (!release_pulse[0] && edges < 20);
        check("release_latency", 32'(edges), 32'd6);
        repeat (5) step();

        repeat (10) begin
            buttons_in[1] = 1'b0; repeat (3) step();
            buttons_in[1] = 1'b1; repeat (3) step();
        end
        check("glitch_pressed1", 32'(pressed[1]), 32'd0);

        buttons_in[2] = 1'b0;
        repeat (90) step();
        buttons_in[2] = 1'b1;
        repeat (30) step();

        buttons_in[0] = 1'b0; buttons_in[3] = 1'b0;
        edges = 0;
        do begin step(); edges++; end while (press_pulse == '0 && edges < 20);
        check("simul_press", 32'(press_pulse), 32'h9);
        repeat (10) step();
        buttons_in = '1;
        repeat (10) step();

        buttons_in[2] = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        edges = 0;
        do begin step(); edges++; end while (!press_pulse[2] && edges < 20);
        check("post_reset_latency", 32'(edges), 32'd6);
        buttons_in[2] = 1'b1;
        repeat (10) step();

        for (int c = 0; c < CH; c++) rem[c] = 0;
        repeat (3000) begin
            for (int c = 0; c < CH; c++) begin
                if (rem[c] == 0) begin
                    buttons_in[c] = ~buttons_in[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 6));
                end else rem[c]--;
            end
            reset = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
